// File: rtl/rsa_operand_loader.sv
// Bus front end for the modexp core: assembles five operands from a word stream,
// launches the core, and streams the result back. Optional macro: LOADER_CYCLE_COUNT_EN.
module rsa_operand_loader #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_sel,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              go,
    output logic              busy,
    output logic              err,
    output logic              done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              exp_start,
    input  logic              exp_done,
    input  logic [OP_W-1:0]   exp_result,
    output logic [OP_W-1:0]   modulus,
    output logic [OP_W-1:0]   rmodm,
    output logic [OP_W-1:0]   rsqmodm,
    output logic [OP_W-1:0]   exponent,
    output logic [OP_W-1:0]   x,
    output logic [31:0]       cycles
);
    localparam int NWORDS = OP_W / WORD_W;
    localparam int PW     = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   ops_q [5];
    logic [OP_W-1:0]   ops_d [5];
    logic [4:0]        loaded_q, loaded_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [2:0]        cur_sel_q, cur_sel_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              start_q, start_d;
    logic [OP_W-1:0]   res_q, res_d;
    logic              wr_fire, go_ok;
    logic [PW-1:0]     wptr;

    assign wr_ready = (state_q == IDLE) & ~go;
    assign wr_fire  = wr_valid & wr_ready & (wr_sel <= 3'd4);
    assign go_ok    = (state_q == IDLE) & go & (&loaded_q);
    // Switching target abandons the partial operand: its pointer restarts.
    assign wptr     = (wr_sel == cur_sel_q) ? ptr_q : '0;

    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        loaded_d  = loaded_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        err_d     = err_q;
        done_d    = 1'b0;
        start_d   = 1'b0;
        res_d     = res_q;

        if (wr_fire) begin
            cur_sel_d = wr_sel;
            ptr_d     = (wptr == PW'(NWORDS - 1)) ? '0 : wptr + 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (wr_sel == 3'(i)) begin
                    ops_d[i] = {wr_data, ops_q[i][OP_W-1:WORD_W]};
                    if (wptr == '0)                loaded_d[i] = 1'b0;
                    if (wptr == PW'(NWORDS - 1))   loaded_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (go) begin
                    if (&loaded_q) begin
                        err_d   = 1'b0;
                        start_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (exp_done) begin
                    res_d   = exp_result;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_ready) begin
                    res_d = res_q >> WORD_W;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PW'(NWORDS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < 5; i++) ops_q[i] <= '0;
            loaded_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            cur_sel_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            for (int i = 0; i < 5; i++) ops_q[i] <= ops_d[i];
            loaded_q  <= loaded_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            err_q     <= err_d;
            done_q    <= done_d;
            start_q   <= start_d;
            res_q     <= res_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign rd_valid  = (state_q == DRAIN);
    assign rd_data   = rd_valid ? res_q[WORD_W-1:0] : '0;
    assign err       = err_q;
    assign done      = done_q;
    assign exp_start = start_q;
    assign modulus   = ops_q[0];
    assign rmodm     = ops_q[1];
    assign rsqmodm   = ops_q[2];
    assign exponent  = ops_q[3];
    assign x         = ops_q[4];

`ifdef LOADER_CYCLE_COUNT_EN
    logic [31:0] cycles_q;

    // Counts every RUN cycle, including the one carrying exp_done.
    always_ff @(posedge clk) begin
        if (rst)
            cycles_q <= '0;
        else if (go_ok)
            cycles_q <= '0;
        else if (state_q == RUN && cycles_q != 32'hFFFF_FFFF)
            cycles_q <= cycles_q + 32'd1;
    end
    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Randomized bench for rsa_operand_loader against an operand/run reference model.
module tb_rsa_operand_loader;
    localparam int WORD_W = 32;
    localparam int OP_W   = 512;
    localparam int NW     = OP_W / WORD_W;

    logic              clk = 1'b0;
    logic              rst, wr_valid, wr_ready, go, busy, err, done;
    logic              rd_valid, rd_ready, exp_start, exp_done;
    logic [2:0]        wr_sel;
    logic [WORD_W-1:0] wr_data, rd_data;
    logic [OP_W-1:0]   exp_result, modulus, rmodm, rsqmodm, exponent, x;
    logic [31:0]       cycles;

    rsa_operand_loader #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_sel(wr_sel), .wr_data(wr_data), .go(go), .busy(busy), .err(err),
        .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .exp_start(exp_start), .exp_done(exp_done), .exp_result(exp_result),
        .modulus(modulus), .rmodm(rmodm), .rsqmodm(rsqmodm), .exponent(exponent),
        .x(x), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: operand contents, completeness, current word run.
    logic [OP_W-1:0] m_ops [5];
    logic [4:0]      m_loaded;
    int              m_run, m_last;

    task automatic chk(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset;
        for (int i = 0; i < 5; i++) m_ops[i] = '0;
        m_loaded = '0;
        m_run    = 0;
        m_last   = 0;
    endtask

    task automatic chk_ops(input string tag);
        chk({tag, "_mod"}, modulus,  m_ops[0]);
        chk({tag, "_rm"},  rmodm,    m_ops[1]);
        chk({tag, "_rsq"}, rsqmodm,  m_ops[2]);
        chk({tag, "_exp"}, exponent, m_ops[3]);
        chk({tag, "_x"},   x,        m_ops[4]);
    endtask

    task automatic wr_word(input int sel, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_sel   = 3'(sel);
        wr_data  = d;
        chk("wr_ready_idle", wr_ready, 1);
        tick;
        wr_valid = 1'b0;
        if (sel <= 4) begin
            if (sel != m_last) m_run = 0;
            if (m_run % NW == 0) m_loaded[sel] = 1'b0;
            m_ops[sel] = {d, m_ops[sel][OP_W-1:WORD_W]};
            m_run++;
            if (m_run % NW == 0) m_loaded[sel] = 1'b1;
            m_last = sel;
        end
    endtask

    task automatic load_op(input int sel, input int n, input bit seq);
        for (int i = 0; i < n; i++) wr_word(sel, seq ? 32'(i + 1) : $urandom);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_reset();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_exp_start", exp_start, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_cycles", cycles, 0);
        chk_ops("rst");
    endtask

    task automatic try_go_fail;
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("gofail_err", err, 1);
        chk("gofail_start", exp_start, 0);
        chk("gofail_busy", busy, 0);
        tick;
        chk("err_sticky", err, 1);
    endtask

    // mode 0: full run; 1: reset mid-RUN; 2: reset mid-DRAIN.
    // rdmode 0: rd_ready held; 1: 1,0,1,0 toggle; 2: random.
    task automatic run(input int lat, input int mode, input int rdmode, input logic [OP_W-1:0] res);
        int idx, it, exp_cyc;
        bit hs;
`ifdef LOADER_CYCLE_COUNT_EN
        exp_cyc = lat;
`else
        exp_cyc = 0;
`endif
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("go_start", exp_start, 1);
        chk("go_busy", busy, 1);
        chk("go_err_clr", err, 0);
        chk_ops("go");
        for (int i = 1; i < lat; i++) begin
            if (mode == 1 && i == lat / 2) begin
                do_reset();
                return;
            end
            wr_valid = 1'b1;
            wr_sel   = 3'($urandom_range(0, 4));
            wr_data  = $urandom;
            chk("run_wr_ready", wr_ready, 0);
            tick;
            wr_valid = 1'b0;
            chk("start_one_cycle", exp_start, 0);
        end
        exp_done   = 1'b1;
        exp_result = res;
        tick;
        exp_done   = 1'b0;
        exp_result = {16{$urandom}};
        chk("cycles", cycles, exp_cyc);
        chk_ops("run_hold");
        idx = 0;
        it  = 0;
        while (idx < NW && it < 200) begin
            chk("rd_valid", rd_valid, 1);
            chk($sformatf("rd_data%0d", idx), rd_data, res[idx*WORD_W +: WORD_W]);
            chk("drain_done", done, 0);
            if (mode == 2 && idx == 5) begin
                do_reset();
                return;
            end
            case (rdmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (it % 2 == 0);
                default: rd_ready = 1'($urandom);
            endcase
            hs = rd_valid & rd_ready;
            tick;
            if (hs) idx++;
            it++;
        end
        rd_ready = 1'b0;
        chk("drain_count", idx, NW);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_rd_valid", rd_valid, 0);
        tick;
        chk("done_once", done, 0);
        chk("cycles_hold", cycles, exp_cyc);
        exp_done = 1'b1;
        tick;
        exp_done = 1'b0;
        chk("idle_exp_done_ignored", rd_valid, 0);
        chk("idle_busy", busy, 0);
        chk_ops("post");
    endtask

    logic [OP_W-1:0] pat, rres;

    initial begin
        rst = 1'b1; wr_valid = 0; wr_sel = 0; wr_data = 0; go = 0;
        rd_ready = 0; exp_done = 0; exp_result = '0;
        m_reset();
        tick;
        do_reset();

        // Sequential operands, byte-pattern result, 40-cycle core.
        for (int s = 0; s < 5; s++) load_op(s, NW, 1'b1);
        chk("mod_lsw", modulus[31:0], 1);
        chk("mod_msw", modulus[511:480], 16);
        for (int b = 0; b < OP_W / 8; b++) pat[b*8 +: 8] = 8'(b);
        run(40, 0, 0, pat);

        // Reload only x.
        load_op(4, NW, 1'b0);
        for (int k = 0; k < NW; k++) rres[k*32 +: 32] = $urandom;
        run($urandom_range(1, 30), 0, 2, rres);

        // Incomplete exponent, then complete it.
        load_op(3, NW - 1, 1'b0);
        try_go_fail();
        wr_word(3, $urandom);
        for (int k = 0; k < NW; k++) rres[k*32 +: 32] = $urandom;
        run(5, 0, 1, rres);

        // Abandon modulus after 7 words; reserved selects are discarded.
        load_op(0, 7, 1'b0);
        wr_word(5, $urandom);
        wr_word(7, $urandom);
        load_op(4, NW, 1'b0);
        chk_ops("reserved");
        try_go_fail();
        load_op(0, NW, 1'b0);
        for (int k = 0; k < NW; k++) rres[k*32 +: 32] = $urandom;
        run(1, 0, 1, rres);

        // Reset mid-RUN and mid-DRAIN.
        run(20, 1, 0, rres);
        try_go_fail();
        for (int s = 0; s < 5; s++) load_op(s, NW, 1'b0);
        run(10, 2, 0, rres);
        try_go_fail();

        // Random load sequences; the model decides whether go should succeed.
        for (int s = 0; s < 5; s++) load_op(s, NW, 1'b0);
        for (int iter = 0; iter < 8; iter++) begin
            load_op($urandom_range(0, 4), $urandom_range(1, 20), 1'b0);
            if (m_loaded == 5'h1F) begin
                for (int k = 0; k < NW; k++) rres[k*32 +: 32] = $urandom;
                run($urandom_range(1, 25), 0, 2, rres);
            end else begin
                try_go_fail();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rsa_operand_loader.md
# rsa_operand_loader

Bus-side front end for the modular exponentiation core. It assembles five 512-bit operands from a 32-bit word stream (modulus, R mod m, R² mod m, exponent, x) and holds them stable while the core runs. It launches the core with a one-cycle start pulse, captures the 512-bit result on the core's done, and streams the result back out as 16 32-bit words. It sits between the processor/DMA interface and the exponentiation core.

## Interface
Parameters:
- `WORD_W`, 32, bus word width.
- `OP_W`, 512, operand width; `OP_W/WORD_W` (16) words per operand.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_valid`  in  1  input word valid.
- `wr_ready`  out  1  input word accepted when high with `wr_valid`.
- `wr_sel`  in  3  target operand: 0 modulus, 1 Rmodm, 2 Rsquaredmodm, 3 exponent, 4 x; 5–7 reserved.
- `wr_data`  in  WORD_W  operand word, least-significant word first.
- `go`  in  1  run request, single-cycle pulse.
- `busy`  out  1  high in RUN and DRAIN.
- `err`  out  1  sticky: `go` rejected because operands are incomplete.
- `done`  out  1  one-cycle pulse after the last result word is accepted.
- `rd_valid`  out  1  result word valid.
- `rd_ready`  in  1  consumer accepts result word.
- `rd_data`  out  WORD_W  result word, least-significant word first.
- `exp_start`  out  1  start pulse to the core.
- `exp_done`  in  1  core done, one-cycle pulse.
- `exp_result`  in  OP_W  core result, valid when `exp_done` is high.
- `modulus`, `rmodm`, `rsqmodm`, `exponent`, `x`  out  OP_W each  operand registers, wired to the core.
- `cycles`  out  32  run-length counter (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN.
- `wr_ready` = (state==IDLE) & ~`go`. A write is accepted on `wr_valid & wr_ready` with `wr_sel` ≤ 4.
- Accepted write: selected register <= {`wr_data`, reg[OP_W-1:WORD_W]}. After 16 writes the first word ends up in bits [31:0].
- Shared 4-bit word pointer `ptr` and last-target register `cur_sel`:
  - If `wr_sel`≠`cur_sel`, `ptr` restarts at 0 and the `loaded` bit of the abandoned operand stays 0.
  - On the first word of an operand (`ptr`=0), that operand's `loaded` bit clears.
  - On the 16th word (`ptr`=15), the `loaded` bit sets and `ptr` wraps to 0.
- Writes with `wr_sel` 5–7 are accepted and discarded, with no state change.
- Loaded operands persist across runs. Reloading only `x` is legal.
- `go` in IDLE:
  - `loaded`==5'b11111: clear `err`, go to RUN, assert `exp_start` next cycle.
  - Otherwise: set `err`, stay in IDLE.
- `go` in RUN or DRAIN is ignored.
- RUN: on `exp_done`, capture `exp_result` into a result shift register, zero the result word counter, go to DRAIN.
- DRAIN:
  - `rd_valid`=1 and `rd_data`=res[31:0].
  - Each `rd_valid & rd_ready` shifts res right by WORD_W and increments the counter.
  - The 16th handshake returns the FSM to IDLE and pulses `done`.
- `exp_done` outside RUN is ignored.

## Timing
- Reset values: state IDLE; `wr_ready`=1 (when `go`=0); `busy`, `err`, `done`, `rd_valid`, `exp_start`=0; `rd_data`=0; all operand registers, `loaded`, `ptr`, `cur_sel`, `cycles`=0.
- `go` accepted at edge T: `exp_start`=1 for exactly cycle T+1 (registered); `busy`=1 from T+1.
- Operand outputs do not change from the `go` edge until return to IDLE.
- `exp_done` high in cycle C: `rd_valid`=1 from C+1. Minimum drain is 16 cycles with `rd_ready` held high.
- `done` is high in the cycle after the 16th read handshake, together with `busy`=0.
- `rst` asserted at any time (including mid-RUN or mid-DRAIN): next edge gives reset values; in-flight result is lost.

## Configuration
- `LOADER_CYCLE_COUNT_EN` defined:
  - `cycles` clears on accepted `go`.
  - It increments every cycle in RUN, including the `exp_done` cycle, and saturates at 32'hFFFFFFFF.
  - It holds its value until the next accepted `go`.
- Not defined: `cycles` is tied to 0 and no counter logic is synthesized.

## Test plan
- Load all five operands (16 words each, word i = i+1), pulse `go` → `exp_start` high exactly one cycle at T+1; `modulus[31:0]`=1, `modulus[511:480]`=16; `busy`=1.
- Core model returns `exp_done` with `exp_result`=512'h…0F0E…0100 after 40 cycles; `rd_ready`=1 → 16 words LSW first, `done` pulses once, FSM back in IDLE; `cycles`=40 with the macro, 0 without.
- Load only 15 words of exponent, then `go` → `err`=1, no `exp_start`, `busy`=0; complete the load and `go` again → `err`=0 and the run starts.
- Switch `wr_sel` from 0 to 4 after 7 words → modulus `loaded` stays 0; `go` sets `err`; 16 fresh modulus words then `go` succeeds.
- Toggle `rd_ready` 1,0,1,0 during DRAIN → `rd_data` advances only on handshakes, no word skipped or duplicated; `wr_valid` during RUN sees `wr_ready`=0 and the operands are unchanged.
- Assert `rst` mid-RUN and mid-DRAIN → all outputs at reset values next cycle; a later `go` sets `err` because `loaded` is cleared.
